// File: rtl/multi_line_fifo.sv
// Cascaded line-buffer FIFOs with a TAPS-wide sliding window per row.
// Optional synchronous flush port enabled by defining MULTI_LINE_FIFO_FLUSH_EN.
module multi_line_fifo #(
  parameter int unsigned ADDR_BIT = 3,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned ROWS     = 3,
  parameter int unsigned TAPS     = 3
) (
  input  logic                            clk,
  input  logic                            rst,
`ifdef MULTI_LINE_FIFO_FLUSH_EN
  input  logic                            flush,
`endif
  input  logic                            wen,
  input  logic [WIDTH-1:0]                in,
  input  logic [ADDR_BIT:0]               depth,
  output logic [ROWS*TAPS*WIDTH-1:0]      out,
  output logic                            out_valid,
  output logic [ROWS-1:0]                 empty,
  output logic [ROWS-1:0]                 full,
  output logic [ROWS-1:0]                 almost_full,
  output logic [ROWS*(ADDR_BIT+1)-1:0]    cnt
);

  localparam int unsigned CW   = ADDR_BIT + 1;
  localparam int unsigned MAXD = 1 << ADDR_BIT;

  logic [WIDTH-1:0]    mem      [ROWS][MAXD];
  logic [WIDTH-1:0]    win_q    [ROWS][TAPS];
  logic [CW-1:0]       cnt_q    [ROWS];
  logic [ADDR_BIT-1:0] wr_ptr_q [ROWS];
  logic [ADDR_BIT-1:0] rd_ptr_q [ROWS];
  logic [CW-1:0]       d_q;
  logic [CW-1:0]       d_clamp_c;
  logic [WIDTH-1:0]    head_c   [ROWS];
  logic [WIDTH-1:0]    din_c    [ROWS];
  logic [ROWS-1:0]     push_c;
  logic [ROWS-1:0]     pop_c;
  logic                clear_c;
  logic                all_empty_c;

`ifdef MULTI_LINE_FIFO_FLUSH_EN
  assign clear_c = !rst || flush;
`else
  assign clear_c = !rst;
`endif

  // Pointers wrap at the effective depth, not at the RAM size.
  function automatic logic [ADDR_BIT-1:0] ptr_next(input logic [ADDR_BIT-1:0] p,
                                                   input logic [CW-1:0] d);
    return ({1'b0, p} == d - CW'(1)) ? '0 : p + ADDR_BIT'(1);
  endfunction

  always_comb begin
    d_clamp_c = depth;
    if (depth < CW'(TAPS))
      d_clamp_c = CW'(TAPS);
    else if (depth > CW'(MAXD))
      d_clamp_c = CW'(MAXD);
  end

  // A full stage hands its head word to the next stage on every push.
  always_comb begin
    push_c    = '0;
    pop_c     = '0;
    push_c[0] = wen;
    for (int r = 0; r < ROWS; r++) begin
      head_c[r] = mem[r][rd_ptr_q[r]];
      pop_c[r]  = wen && (cnt_q[r] == d_q);
      din_c[r]  = in;
    end
    for (int r = 1; r < ROWS; r++) begin
      push_c[r] = pop_c[r-1];
      din_c[r]  = head_c[r-1];
    end
  end

  always_comb begin
    out         = '0;
    cnt         = '0;
    empty       = '0;
    full        = '0;
    almost_full = '0;
    for (int r = 0; r < ROWS; r++) begin
      cnt[r*CW +: CW] = cnt_q[r];
      empty[r]        = (cnt_q[r] == '0);
      full[r]         = (cnt_q[r] == d_q);
      almost_full[r]  = (cnt_q[r] == d_q - CW'(1));
      for (int t = 0; t < TAPS; t++)
        out[(r*TAPS+t)*WIDTH +: WIDTH] = win_q[r][t];
    end
    all_empty_c = &empty;
  end

  // Storage RAM is not cleared by reset or flush.
  always_ff @(posedge clk) begin
    for (int r = 0; r < ROWS; r++)
      if (!clear_c && push_c[r])
        mem[r][wr_ptr_q[r]] <= din_c[r];
  end

  always_ff @(posedge clk) begin
    if (clear_c) begin
      d_q       <= d_clamp_c;
      out_valid <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        cnt_q[r]    <= '0;
        wr_ptr_q[r] <= '0;
        rd_ptr_q[r] <= '0;
        for (int t = 0; t < TAPS; t++)
          win_q[r][t] <= '0;
      end
    end else begin
      if (all_empty_c)
        d_q <= d_clamp_c;
      if (wen && full[ROWS-1])
        out_valid <= 1'b1;
      for (int r = 0; r < ROWS; r++) begin
        if (push_c[r]) begin
          wr_ptr_q[r] <= ptr_next(wr_ptr_q[r], d_q);
          if (!pop_c[r])
            cnt_q[r] <= cnt_q[r] + CW'(1);
          for (int t = TAPS - 1; t > 0; t--)
            win_q[r][t] <= win_q[r][t-1];
          win_q[r][0] <= din_c[r];
        end
        if (pop_c[r])
          rd_ptr_q[r] <= ptr_next(rd_ptr_q[r], d_q);
      end
    end
  end

endmodule

// File: tb/tb_multi_line_fifo.sv
// Directed self-checking bench for multi_line_fifo at default parameters.
module tb_multi_line_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wen = 1'b0;
  logic [7:0]  in = '0;
  logic [3:0]  depth = 4'd8;
  logic [71:0] out;
  logic        out_valid;
  logic [2:0]  empty, full, almost_full;
  logic [11:0] cnt;
`ifdef MULTI_LINE_FIFO_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int passed = 0;
  int total  = 0;
  int next_val = 0;

  multi_line_fifo dut (
    .clk(clk),
    .rst(rst),
`ifdef MULTI_LINE_FIFO_FLUSH_EN
    .flush(flush),
`endif
    .wen(wen),
    .in(in),
    .depth(depth),
    .out(out),
    .out_valid(out_valid),
    .empty(empty),
    .full(full),
    .almost_full(almost_full),
    .cnt(cnt)
  );

  always #5 clk = ~clk;

  // Window image with newest tap values n0/n1/n2 per row, older taps counting down.
  function automatic logic [71:0] win_exp(input int n0, input int n1, input int n2);
    logic [71:0] v;
    int n [3];
    n[0] = n0; n[1] = n1; n[2] = n2;
    v = '0;
    for (int r = 0; r < 3; r++)
      for (int t = 0; t < 3; t++)
        v[(r*3+t)*8 +: 8] = 8'(n[r] - t);
    return v;
  endfunction

  task automatic cycle(input bit w);
    wen = w;
    in  = 8'(next_val);
    @(posedge clk);
    #1;
    wen = 1'b0;
    if (w) next_val++;
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1);
  endtask

  task automatic do_reset(input logic [3:0] d);
    depth = d;
    rst = 1'b0;
    wen = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    next_val = 0;
  endtask

  task automatic test_reset;
    do_reset(4'd8);
    total++; if (cnt !== 12'h000) $display("FAIL reset_cnt got %h expected 000", cnt); else passed++;
    total++; if (out !== 72'h0) $display("FAIL reset_out got %h expected 0", out); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b expected 0", out_valid); else passed++;
    total++; if (empty !== 3'b111) $display("FAIL reset_empty got %b expected 111", empty); else passed++;
    total++; if (full !== 3'b000) $display("FAIL reset_full got %b expected 000", full); else passed++;
    total++; if (almost_full !== 3'b000) $display("FAIL reset_afull got %b expected 000", almost_full); else passed++;
  endtask

  task automatic test_full_window;
    logic [71:0] e;
    do_reset(4'd8);
    push_n(24);
    total++; if (out_valid !== 1'b0) $display("FAIL win24_valid got %b expected 0", out_valid); else passed++;
    total++; if (full !== 3'b111) $display("FAIL win24_full got %b expected 111", full); else passed++;
    push_n(1);
    e = win_exp(24, 16, 8);
    total++; if (out_valid !== 1'b1) $display("FAIL win25_valid got %b expected 1", out_valid); else passed++;
    total++; if (out !== e) $display("FAIL win25_out got %h expected %h", out, e); else passed++;
    total++; if (cnt !== 12'h888) $display("FAIL win25_cnt got %h expected 888", cnt); else passed++;
    for (int i = 0; i < 5; i++) cycle(1'b0);
    total++; if (out !== e) $display("FAIL hold_out got %h expected %h", out, e); else passed++;
    total++; if (cnt !== 12'h888) $display("FAIL hold_cnt got %h expected 888", cnt); else passed++;
    total++; if (out_valid !== 1'b1) $display("FAIL hold_valid got %b expected 1", out_valid); else passed++;
  endtask

  task automatic test_depth_clamp;
    logic [3:0] dl [2];
    dl[0] = 4'd0; dl[1] = 4'd2;
    for (int k = 0; k < 2; k++) begin
      do_reset(dl[k]);
      push_n(2);
      total++; if (almost_full[0] !== 1'b1) $display("FAIL clamp%0d_afull got %b expected 1", k, almost_full[0]); else passed++;
      total++; if (full[0] !== 1'b0) $display("FAIL clamp%0d_full2 got %b expected 0", k, full[0]); else passed++;
      push_n(1);
      total++; if (full[0] !== 1'b1) $display("FAIL clamp%0d_full3 got %b expected 1", k, full[0]); else passed++;
      total++; if (cnt[3:0] !== 4'd3) $display("FAIL clamp%0d_cnt got %0d expected 3", k, cnt[3:0]); else passed++;
    end
    push_n(1);
    total++; if (cnt[7:4] !== 4'd1) $display("FAIL clamp_cnt1 got %0d expected 1", cnt[7:4]); else passed++;
    total++; if (out[31:24] !== 8'd0) $display("FAIL clamp_row1tap0 got %0d expected 0", out[31:24]); else passed++;
    do_reset(4'd12);
    push_n(7);
    total++; if (full[0] !== 1'b0 || almost_full[0] !== 1'b1) $display("FAIL clamp12_7 got full %b afull %b expected 0 1", full[0], almost_full[0]); else passed++;
    push_n(1);
    total++; if (full[0] !== 1'b1) $display("FAIL clamp12_8 got %b expected 1", full[0]); else passed++;
  endtask

  task automatic test_depth_change;
    do_reset(4'd8);
    push_n(5);
    depth = 4'd4;
    push_n(2);
    total++; if (full[0] !== 1'b0 || cnt[3:0] !== 4'd7) $display("FAIL dchg_7 got full %b cnt %0d expected 0 7", full[0], cnt[3:0]); else passed++;
    push_n(1);
    total++; if (full[0] !== 1'b1) $display("FAIL dchg_8 got %b expected 1", full[0]); else passed++;
    do_reset(4'd4);
    push_n(3);
    total++; if (full[0] !== 1'b0 || almost_full[0] !== 1'b1) $display("FAIL d4_3 got full %b afull %b expected 0 1", full[0], almost_full[0]); else passed++;
    push_n(1);
    total++; if (full[0] !== 1'b1) $display("FAIL d4_4 got %b expected 1", full[0]); else passed++;
  endtask

  // D=3 cascade exercises pointer wrap at 3 in every stage.
  task automatic test_fifo_order;
    logic [71:0] e;
    do_reset(4'd3);
    push_n(9);
    total++; if (out_valid !== 1'b0) $display("FAIL ord9_valid got %b expected 0", out_valid); else passed++;
    push_n(1);
    e = win_exp(9, 6, 3);
    total++; if (out_valid !== 1'b1) $display("FAIL ord10_valid got %b expected 1", out_valid); else passed++;
    total++; if (out !== e) $display("FAIL ord10_out got %h expected %h", out, e); else passed++;
    total++; if (cnt !== 12'h333) $display("FAIL ord10_cnt got %h expected 333", cnt); else passed++;
  endtask

  task automatic test_mid_reset;
    do_reset(4'd8);
    push_n(13);
    do_reset(4'd8);
    total++; if (cnt !== 12'h000) $display("FAIL mrst_cnt got %h expected 000", cnt); else passed++;
    total++; if (out !== 72'h0) $display("FAIL mrst_out got %h expected 0", out); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL mrst_valid got %b expected 0", out_valid); else passed++;
    total++; if (empty !== 3'b111) $display("FAIL mrst_empty got %b expected 111", empty); else passed++;
    push_n(1);
    total++; if (cnt !== 12'h001) $display("FAIL mrst_push got %h expected 001", cnt); else passed++;
  endtask

`ifdef MULTI_LINE_FIFO_FLUSH_EN
  task automatic test_flush;
    do_reset(4'd8);
    push_n(25);
    flush = 1'b1;
    cycle(1'b1);
    flush = 1'b0;
    total++; if (cnt !== 12'h000 || empty !== 3'b111) $display("FAIL flush_cnt got %h empty %b expected 000 111", cnt, empty); else passed++;
    total++; if (out !== 72'h0 || out_valid !== 1'b0) $display("FAIL flush_out got %h valid %b expected 0 0", out, out_valid); else passed++;
    total++; if (full !== 3'b000 || almost_full !== 3'b000) $display("FAIL flush_full got %b afull %b expected 000 000", full, almost_full); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_full_window();
    test_depth_clamp();
    test_depth_change();
    test_fifo_order();
    test_mid_reset();
`ifdef MULTI_LINE_FIFO_FLUSH_EN
    test_flush();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multi_line_fifo.md
MULTI_LINE_FIFO -- requirements
Module: multi_line_fifo

Interface
REQ-001 SHALL have parameter ADDR_BIT, default 3, storage per stage = 2^ADDR_BIT words.
REQ-002 SHALL have parameter WIDTH, default 8, data word width.
REQ-003 SHALL have parameter ROWS, default 3, number of cascaded FIFO stages (legal range 1..8).
REQ-004 SHALL have parameter TAPS, default 3, window taps per row (legal range 1..2^ADDR_BIT).
REQ-005 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-007 SHALL have port wen  input  1  push request for in.
REQ-008 SHALL have port in  input  WIDTH  pixel/data word.
REQ-009 SHALL have port depth  input  ADDR_BIT+1  requested line length per stage.
REQ-010 SHALL have port out  output  ROWS*TAPS*WIDTH  window; row r, tap t at bits (r*TAPS+t)*WIDTH +: WIDTH; tap 0 = newest.
REQ-011 SHALL have port out_valid  output  1  window aligned and complete.
REQ-012 SHALL have ports empty, full, almost_full  output  ROWS  per-stage status, bit r = stage r.
REQ-013 SHALL have port cnt  output  ROWS*(ADDR_BIT+1)  per-stage occupancy, stage r at bits r*(ADDR_BIT+1) +: ADDR_BIT+1.

Function
REQ-014 Effective depth D SHALL be depth clamped to [TAPS, 2^ADDR_BIT] (0 and values below TAPS -> TAPS; above 2^ADDR_BIT -> 2^ADDR_BIT).
REQ-015 D SHALL be re-sampled only on cycles where all stages are empty; depth changes at any other time are ignored.
REQ-016 Push accepted whenever wen=1; there is no back-pressure; wen=0 freezes all state (counts, data, out, out_valid).
REQ-017 On accepted push, stage 0 receives in; for each stage r with cnt_r==D (before the push), its head word SHALL be popped and pushed into stage r+1 in the same cycle; the pop from stage ROWS-1 is discarded.
REQ-018 cnt_r SHALL increment by 1 on a push into stage r without a pop, and stay unchanged on simultaneous push and pop; never exceeds D.
REQ-019 Row r window SHALL be a TAPS-deep shift register of the last TAPS words pushed into stage r, updated one cycle after the push (registered).
REQ-020 empty[r] = (cnt_r==0), full[r] = (cnt_r==D), almost_full[r] = (cnt_r==D-1); all combinational from registered counts.
REQ-021 out_valid SHALL be registered: 1 in the cycle after an accepted push during which full[ROWS-1] was already 1 before the push; otherwise held when wen=0, cleared only by reset/flush.
REQ-022 Data order SHALL be FIFO; read/write pointers wrap modulo D, not 2^ADDR_BIT.

Reset
REQ-023 While rst=0 at a clock edge: all cnt=0, pointers=0, out=0, out_valid=0, empty=all ones, full=0, almost_full=0, D re-sampled from depth.
REQ-024 Reset mid-operation SHALL discard all stored data; first push after release lands in stage 0 at count 1.

Configuration
REQ-025 Macro MULTI_LINE_FIFO_FLUSH_EN defined: extra input port flush (1 bit, after rst); flush=1 at a clock edge SHALL apply REQ-023 state (storage RAM untouched) and take priority over wen.
REQ-026 Macro MULTI_LINE_FIFO_FLUSH_EN undefined: no flush port; behaviour otherwise identical.

Verification (ROWS=3, TAPS=3, ADDR_BIT=3, WIDTH=8, in = 0,1,2,... one per accepted push)
REQ-027 depth=8, 25 consecutive pushes (0..24) -> out_valid rises the cycle after push 24; row0 taps = 24,23,22; row1 = 16,15,14; row2 = 8,7,6; cnt all 8, full=3'b111.
REQ-028 depth=8, 24 pushes -> out_valid=0, full=3'b111; one more push -> out_valid=1; wen=0 for 5 cycles -> out, cnt, out_valid unchanged.
REQ-029 depth=0 and depth=2 -> D=3; depth=12 -> D=8; after 3 pushes full[0]=1, almost_full[0]=1 after 2 pushes (D=3).
REQ-030 depth changed from 8 to 4 after 5 pushes -> ignored (full[0] only after 8th push); after reset with depth=4 -> full[0] after 4th push.
REQ-031 rst=0 for one cycle after 13 pushes -> next cycle cnt=0, out=0, out_valid=0, empty=3'b111; subsequent push of 0 gives cnt0=1.
REQ-032 MULTI_LINE_FIFO_FLUSH_EN defined, flush=1 with wen=1 after 25 pushes -> push ignored, state equals reset state next cycle.
